// File: rtl/dmem_if.sv
// M-stage data-memory bus between the pipelined core and its data memory.
interface dmem_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;

  modport master (
    output MemReadM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadDataM, MemStallM, MisalignM
  );

  modport slave (
    input  MemReadM, MemWriteM, ALUOutM, WriteDataM,
    output ReadDataM, MemStallM, MisalignM
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with a fixed multi-cycle access latency.
// Stalls the M stage while an access is in flight and rejects misaligned requests.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     rdata_q;
  logic            misalign_q;
  logic            wr_q;

  logic            req_c;
  logic            misaligned_c;
  logic [AW-1:0]   idx_c;
  logic            stall_c;
  logic            misalign_n;
  logic            enter_done_c;
  logic            unused_addr_bits;

  assign req_c            = bus.MemReadM | bus.MemWriteM;
  assign misaligned_c     = bus.ALUOutM[1:0] != 2'b00;
  assign idx_c            = bus.ALUOutM[AW+1:2];
  assign unused_addr_bits = ^bus.ALUOutM[31:AW+2];

  // Stall is combinational so the core freezes in the request cycle; forced low in reset.
  assign bus.MemStallM = stall_c & reset;
  assign bus.ReadDataM = rdata_q;
  assign bus.MisalignM = misalign_q;

  // Next-state, latency counter and per-cycle control strobes.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    stall_c      = 1'b0;
    misalign_n   = 1'b0;
    enter_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (misaligned_c) begin
            misalign_n = 1'b1;
          end else begin
            stall_c = 1'b1;
            if (LATENCY == 1) begin
              state_n      = DONE;
              enter_done_c = 1'b1;
            end else begin
              state_n = BUSY;
              cnt_n   = CNT_INIT;
            end
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (!req_c) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_n      = DONE;
          cnt_n        = '0;
          enter_done_c = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Load data captured on entry to DONE; op type latched so a late req drop still completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      misalign_q <= misalign_n;
      if (enter_done_c) begin
        wr_q <= bus.MemWriteM;
        if (!bus.MemWriteM) begin
          rdata_q <= mem_q[idx_c];
        end
      end
    end
  end

  // Store commits at the end of the DONE cycle; reset clears the whole array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == DONE && wr_q) begin
      mem_q[idx_c] <= bus.WriteDataM;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 1, 2 and 4,
// exercised one after another with directed and random traffic.
module tb_dmem_responder;

  localparam int unsigned NDUT  = 3;
  localparam int unsigned DEPTH = 64;
  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_MIS = 2;

  function automatic int unsigned lat_of(int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n   [NDUT];
  logic        rd_i    [NDUT];
  logic        wr_i    [NDUT];
  logic [31:0] addr_i  [NDUT];
  logic [31:0] wdat_i  [NDUT];
  logic [31:0] rdata_o [NDUT];
  logic        stall_o [NDUT];
  logic        mis_o   [NDUT];

  logic [31:0] model_mem [NDUT][DEPTH];
  logic [31:0] last_rd   [NDUT];
  exp_t        expq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_if bus();
    assign bus.MemReadM   = rd_i[g];
    assign bus.MemWriteM  = wr_i[g];
    assign bus.ALUOutM    = addr_i[g];
    assign bus.WriteDataM = wdat_i[g];
    assign rdata_o[g]     = bus.ReadDataM;
    assign stall_o[g]     = bus.MemStallM;
    assign mis_o[g]       = bus.MisalignM;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(lat_of(g))) u_dut (
      .clk   (clk),
      .reset (rst_n[g]),
      .bus   (bus.slave)
    );
  end

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d, LATENCY=%0d): got %h, expected %h", name, d, lat_of(d), act, exp);
    end
  endtask

  task automatic model_reset(int d);
    for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
    last_rd[d] = '0;
  endtask

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic clear_inputs(int d);
    rd_i[d]   = 1'b0;
    wr_i[d]   = 1'b0;
    addr_i[d] = '0;
    wdat_i[d] = '0;
  endtask

  // Monitor: every completion or misalign pulse consumes one scoreboard entry.
  task automatic consume(int d, int seen_kind);
    exp_t e;
    if (expq.size() == 0 || expq[0].dut != d) begin
      checks++;
      errors++;
      $display("FAIL unexpected event (dut%0d): kind %0d with empty scoreboard", d, seen_kind);
    end else begin
      e = expq.pop_front();
      check("event kind", d, 32'(seen_kind), 32'(e.kind));
      check("ReadDataM", d, rdata_o[d], e.data);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_n[d] === 1'b1) begin
        if (mis_o[d] === 1'b1) consume(d, K_MIS);
        if ((rd_i[d] | wr_i[d]) && addr_i[d][1:0] == 2'b00 && stall_o[d] === 1'b0)
          consume(d, wr_i[d] ? K_ST : K_LD);
      end
    end
  end

  // One request: predict the outcome, drive it, and check the stall length.
  task automatic access(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int   n;
    bit   done;
    e.dut = d;
    if (a[1:0] != 2'b00) begin
      e.kind = K_MIS;
      e.data = last_rd[d];
    end else if (wr) begin
      model_mem[d][widx(a)] = wd;
      e.kind = K_ST;
      e.data = last_rd[d];
    end else begin
      last_rd[d] = model_mem[d][widx(a)];
      e.kind = K_LD;
      e.data = last_rd[d];
    end
    expq.push_back(e);
    @(posedge clk); #1;
    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wdat_i[d] = wd;
    if (a[1:0] != 2'b00) begin
      @(negedge clk);
      check("no stall on misaligned", d, 32'(stall_o[d]), 32'd0);
      @(posedge clk); #1;
      clear_inputs(d);
      @(negedge clk);
      check("no stall after misaligned", d, 32'(stall_o[d]), 32'd0);
    end else begin
      n = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (stall_o[d] !== 1'b1) begin
          done = 1'b1;
        end else begin
          n++;
          if (n > 40) begin
            check("stall timeout", d, 32'(n), 32'(lat_of(d)));
            done = 1'b1;
          end
        end
      end
      check("stall cycles", d, 32'(n), 32'(lat_of(d)));
      @(posedge clk); #1;
      clear_inputs(d);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Store aborted by dropping the request while the access is still in BUSY.
  task automatic flush_store(int d, logic [31:0] a, logic [31:0] wd);
    int drop;
    drop = (lat_of(d) >= 3) ? 2 : 1;
    @(posedge clk); #1;
    wr_i[d] = 1'b1; addr_i[d] = a; wdat_i[d] = wd;
    repeat (drop) begin
      @(negedge clk);
      check("stall before flush", d, 32'(stall_o[d]), 32'd1);
    end
    @(posedge clk); #1;
    clear_inputs(d);
    @(negedge clk);
    @(negedge clk);
    check("stall after flush", d, 32'(stall_o[d]), 32'd0);
  endtask

  // Reset asserted while a store is in BUSY; request stays high through reset.
  task automatic reset_mid_store(int d, logic [31:0] a, logic [31:0] wd);
    @(posedge clk); #1;
    wr_i[d] = 1'b1; addr_i[d] = a; wdat_i[d] = wd;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n[d] = 1'b0;
    #1;
    check("ReadDataM in reset", d, rdata_o[d], 32'd0);
    check("MemStallM in reset", d, 32'(stall_o[d]), 32'd0);
    check("MisalignM in reset", d, 32'(mis_o[d]), 32'd0);
    model_reset(d);
    @(posedge clk); #1;
    clear_inputs(d);
    @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  task automatic run_directed(int d);
    access(d, 1, 0, 32'h10, 32'h0);
    access(d, 0, 1, 32'h20, 32'hDEADBEEF);
    access(d, 1, 0, 32'h20, 32'h0);
    access(d, 1, 0, 32'h24, 32'h0);
    access(d, 0, 1, 32'h100, 32'h12345678);
    access(d, 1, 0, 32'h000, 32'h0);
    access(d, 1, 0, 32'h13, 32'h0);
    access(d, 0, 1, 32'h22, 32'h11111111);
    access(d, 1, 0, 32'h20, 32'h0);
    access(d, 1, 1, 32'h30, 32'hA5A5A5A5);
    access(d, 1, 0, 32'h30, 32'h0);
    if (lat_of(d) > 1) begin
      flush_store(d, 32'h40, 32'hCAFEF00D);
      access(d, 1, 0, 32'h40, 32'h0);
      access(d, 1, 0, 32'h20, 32'h0);
      reset_mid_store(d, 32'h08, 32'h55AA55AA);
      access(d, 1, 0, 32'h08, 32'h0);
      access(d, 1, 0, 32'h20, 32'h0);
    end
  endtask

  task automatic run_random(int d, int nops);
    int          op;
    logic [31:0] a;
    for (int i = 0; i < nops; i++) begin
      op = $urandom_range(0, 9);
      a  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8)
         | (32'($urandom_range(0, 1)) << 31);
      if (op >= 8) a = a | 32'($urandom_range(1, 3));
      case (op)
        0, 1, 2, 3, 8: access(d, 1, 0, a, 32'h0);
        4, 5, 6, 9:    access(d, 0, 1, a, 32'($urandom));
        default:       access(d, 1, 1, a, 32'($urandom));
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0;
      clear_inputs(d);
      rd_i[d] = 1'b1;
      model_reset(d);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("reset ReadDataM", d, rdata_o[d], 32'd0);
      check("reset MemStallM", d, 32'(stall_o[d]), 32'd0);
      check("reset MisalignM", d, 32'(mis_o[d]), 32'd0);
      clear_inputs(d);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;

    for (int d = 0; d < NDUT; d++) begin
      run_directed(d);
      run_random(d, 40);
    end

    repeat (4) @(posedge clk);
    check("scoreboard drained", 0, 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
